// File: rtl/ctpps_readout_pkg.sv
// Shared word-type codes, FSM state encoding and helpers for the TDC readout scheduler.
package ctpps_readout_pkg;

    localparam logic [3:0] HDR         = 4'hA;
    localparam logic [3:0] DAT         = 4'h3;
    localparam logic [3:0] TRL         = 4'h5;
    localparam logic [3:0] TDC_TRAILER = 4'h3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_SELECT,
        ST_READ,
        ST_WAIT,
        ST_EMIT,
        ST_TRAILER
    } state_t;

    // Increment that sticks at all-ones so the event word count never wraps.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/tdc_readout_scheduler_rr_select.sv
// Rotating-priority picker: first set candidate bit at or above rr_ptr, wrapping mod N_TDC.
module rr_select #(
    parameter int N_TDC = 4,
    parameter int IW    = 2
) (
    input  logic [N_TDC-1:0] cand,
    input  logic [IW-1:0]    rr_ptr,
    output logic [IW-1:0]    grant,
    output logic             grant_valid
);

    logic [IW-1:0] idx;

    // Scan from the farthest offset down so the nearest candidate to rr_ptr wins.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        idx         = '0;
        for (int i = N_TDC - 1; i >= 0; i--) begin
            idx = IW'((int'(rr_ptr) + i) % N_TDC);
            if (cand[idx]) begin
                grant       = idx;
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tdc_readout_scheduler.sv
// Event readout sequencer: header, round-robin drain of the TDC FIFOs, trailer.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | waiting for transmit_request
// ST_HEADER  | header word presented, waiting for out_ready
// ST_SELECT  | pick next unvisited non-empty TDC, or go to trailer
// ST_READ    | read strobe high for the granted TDC
// ST_WAIT    | waiting for input_ready, timeout down-counter running
// ST_EMIT    | load data word, then hold it until accepted
// ST_TRAILER | trailer word presented, waiting for out_ready
module tdc_readout_scheduler #(
    parameter int          N_TDC     = 4,
    parameter int          MAX_WORDS = 64,
    parameter logic [11:0] FEC_ID    = 12'h00A,
    parameter int          TIMEOUT   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  transmit_request,
    input  logic [23:0]           event_number,
    input  logic [15:0]           bunch_number,
    input  logic [N_TDC-1:0]      empty,
    output logic [N_TDC-1:0]      read_enable,
    input  logic [32*N_TDC-1:0]   data_in,
    input  logic [N_TDC-1:0]      input_ready,
    output logic [63:0]           data_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  transmit_complete,
    output logic                  timeout_error
);
    import ctpps_readout_pkg::*;

    localparam int IW = $clog2(N_TDC);
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t            state;
    logic [IW-1:0]     rr_ptr;
    logic [IW-1:0]     gnt;
    logic [IW-1:0]     sel_idx;
    logic              sel_valid;
    logic [N_TDC-1:0]  visited;
    logic [N_TDC-1:0]  cand;
    logic [15:0]       word_cnt;
    logic [7:0]        grant_cnt;
    logic [31:0]       tdc_word;
    logic [TW-1:0]     tmo_cnt;
    logic              unused_bits;

    // Only the low 12 bunch-crossing bits go into the header.
    assign unused_bits = &{1'b0, bunch_number[15:12]};

    assign cand = ~empty & ~visited;

    rr_select #(.N_TDC(N_TDC), .IW(IW)) u_rr_select (
        .cand        (cand),
        .rr_ptr      (rr_ptr),
        .grant       (sel_idx),
        .grant_valid (sel_valid)
    );

    // Main sequencer; read_enable defaults low so every strobe lasts one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= ST_IDLE;
            read_enable       <= '0;
            data_out          <= '0;
            out_valid         <= 1'b0;
            transmit_complete <= 1'b0;
            timeout_error     <= 1'b0;
            rr_ptr            <= '0;
            gnt               <= '0;
            visited           <= '0;
            word_cnt          <= '0;
            grant_cnt         <= '0;
            tdc_word          <= '0;
            tmo_cnt           <= '0;
        end else begin
            transmit_complete <= 1'b0;
            read_enable       <= '0;
            case (state)
                ST_IDLE: begin
                    if (transmit_request) begin
                        visited       <= '0;
                        timeout_error <= 1'b0;
                        word_cnt      <= '0;
                        data_out      <= {HDR, 4'h0, event_number, bunch_number[11:0], FEC_ID, 8'h00};
                        out_valid     <= 1'b1;
                        state         <= ST_HEADER;
                    end
                end
                ST_HEADER: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        word_cnt  <= sat_inc16(word_cnt);
                        state     <= ST_SELECT;
                    end
                end
                ST_SELECT: begin
                    if (sel_valid) begin
                        visited[sel_idx]     <= 1'b1;
                        gnt                  <= sel_idx;
                        grant_cnt            <= '0;
                        read_enable[sel_idx] <= 1'b1;
                        state                <= ST_READ;
                    end else begin
                        data_out  <= {TRL, 4'h0, 8'h00, sat_inc16(word_cnt), 32'h0};
                        out_valid <= 1'b1;
                        state     <= ST_TRAILER;
                    end
                end
                ST_READ: begin
                    tmo_cnt <= TW'(TIMEOUT - 1);
                    state   <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (input_ready[gnt]) begin
                        tdc_word <= data_in[int'(gnt)*32 +: 32];
                        state    <= ST_EMIT;
                    end else if (tmo_cnt == '0) begin
                        timeout_error <= 1'b1;
                        state         <= ST_SELECT;
                    end else begin
                        tmo_cnt <= tmo_cnt - TW'(1);
                    end
                end
                ST_EMIT: begin
                    if (!out_valid) begin
                        data_out  <= {DAT, 1'b0, 3'(gnt), 24'h0, tdc_word};
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        word_cnt  <= sat_inc16(word_cnt);
                        grant_cnt <= grant_cnt + 8'd1;
                        if (tdc_word[31:28] == TDC_TRAILER ||
                            grant_cnt + 8'd1 == 8'(MAX_WORDS) ||
                            empty[gnt]) begin
                            state <= ST_SELECT;
                        end else begin
                            read_enable[gnt] <= 1'b1;
                            state            <= ST_READ;
                        end
                    end
                end
                ST_TRAILER: begin
                    if (out_ready) begin
                        out_valid         <= 1'b0;
                        transmit_complete <= 1'b1;
                        rr_ptr            <= (rr_ptr == IW'(N_TDC - 1)) ? '0 : rr_ptr + IW'(1);
                        state             <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tdc_readout_scheduler.sv
// Directed bench for tdc_readout_scheduler with a behavioural FIFO responder.
module tb_tdc_readout_scheduler;

    localparam int N = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            transmit_request = 1'b0;
    logic [23:0]     event_number = '0;
    logic [15:0]     bunch_number = '0;
    logic [N-1:0]    empty = '1;
    logic [N-1:0]    read_enable;
    logic [32*N-1:0] data_in = '0;
    logic [N-1:0]    input_ready = '0;
    logic [63:0]     data_out;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic            transmit_complete;
    logic            timeout_error;

    int checks = 0;
    int failures = 0;

    logic [31:0] fq [N][$];
    logic [N-1:0] stall = '0;
    logic [N-1:0] pend = '0;
    logic [63:0] cap[$];
    logic [63:0] exp_q[$];
    bit done = 1'b0;

    always #5 clk = ~clk;

    tdc_readout_scheduler #(
        .N_TDC(4), .MAX_WORDS(64), .FEC_ID(12'h00A), .TIMEOUT(4)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .transmit_request  (transmit_request),
        .event_number      (event_number),
        .bunch_number      (bunch_number),
        .empty             (empty),
        .read_enable       (read_enable),
        .data_in           (data_in),
        .input_ready       (input_ready),
        .data_out          (data_out),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .transmit_complete (transmit_complete),
        .timeout_error     (timeout_error)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] hdr(input logic [23:0] ev, input logic [11:0] bx);
        return {4'hA, 4'h0, ev, bx, 12'h00A, 8'h00};
    endfunction

    function automatic logic [63:0] dat(input int g, input logic [31:0] w);
        return {4'h3, 1'b0, 3'(g), 24'h0, w};
    endfunction

    function automatic logic [63:0] trl(input logic [15:0] n);
        return {4'h5, 4'h0, 8'h00, n, 32'h0};
    endfunction

    // FIFO responder and output monitor, all mid-cycle so DUT values are settled.
    always @(negedge clk) begin
        if (rst) begin
            pend = '0;
            input_ready = '0;
        end else begin
            if (read_enable != '0) begin
                chk("re_onehot", 64'($onehot(read_enable)), 64'd1);
                chk("re_while_empty", 64'(read_enable & empty), 64'd0);
            end
            if (out_valid && out_ready) cap.push_back(data_out);
            if (transmit_complete) done = 1'b1;
            input_ready = pend;
            pend = '0;
            for (int i = 0; i < N; i++) begin
                if (read_enable[i]) begin
                    if (fq[i].size() > 0) data_in[32*i +: 32] = fq[i].pop_front();
                    if (!stall[i]) pend[i] = 1'b1;
                end
            end
        end
        for (int i = 0; i < N; i++) empty[i] = (fq[i].size() == 0);
    end

    task automatic load(input int t, input int n, input logic [31:0] base);
        for (int k = 0; k < n; k++) fq[t].push_back(base + 32'(k));
    endtask

    task automatic start_event(input logic [23:0] ev, input logic [15:0] bx);
        cap.delete();
        exp_q.delete();
        done = 1'b0;
        event_number = ev;
        bunch_number = bx;
        @(posedge clk) #1 transmit_request = 1'b1;
        @(posedge clk) #1 transmit_request = 1'b0;
        exp_q.push_back(hdr(ev, bx[11:0]));
    endtask

    task automatic finish_event(input string tag, input int budget);
        int n = 0;
        while (!done && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk($sformatf("%s_complete", tag), 64'(done), 64'd1);
        #1 chk($sformatf("%s_tc_pulse", tag), 64'(transmit_complete), 64'd0);
        chk($sformatf("%s_nwords", tag), 64'(cap.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < cap.size(); i++)
            chk($sformatf("%s_w%0d", tag, i), cap[i], exp_q[i]);
    endtask

    task automatic do_reset();
        @(posedge clk) #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        logic [63:0] snap;
        int n;

        // reset state
        #1 rst = 1'b1;
        #2;
        chk("rst_read_enable", 64'(read_enable), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_data_out", data_out, 64'd0);
        chk("rst_tc", 64'(transmit_complete), 64'd0);
        chk("rst_timeout", 64'(timeout_error), 64'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // FIFO0 with three words ending in a TDC trailer
        fq[0].push_back(32'h0000_0011);
        fq[0].push_back(32'h0000_0022);
        fq[0].push_back(32'h3000_0003);
        start_event(24'h000123, 16'hF456);
        @(negedge clk);
        chk("t1_hdr_valid", 64'(out_valid), 64'd1);
        chk("t1_hdr_data", data_out, 64'hA000_0123_4560_0A00);
        exp_q.push_back(dat(0, 32'h0000_0011));
        exp_q.push_back(dat(0, 32'h0000_0022));
        exp_q.push_back(dat(0, 32'h3000_0003));
        exp_q.push_back(trl(16'd5));
        finish_event("t1", 200);

        // round-robin rotation across two events
        do_reset();
        for (int i = 0; i < N; i++) load(i, 1, 32'h0000_0100 + 32'(i));
        start_event(24'h000200, 16'h0010);
        for (int i = 0; i < N; i++) exp_q.push_back(dat(i, 32'h0000_0100 + 32'(i)));
        exp_q.push_back(trl(16'd6));
        finish_event("t2a", 300);
        for (int i = 0; i < N; i++) load(i, 1, 32'h0000_0200 + 32'(i));
        start_event(24'h000201, 16'h0011);
        for (int i = 1; i <= N; i++) exp_q.push_back(dat(i % N, 32'h0000_0200 + 32'(i % N)));
        exp_q.push_back(trl(16'd6));
        finish_event("t2b", 300);

        // per-grant word cap
        load(2, 100, 32'h0100_0000);
        start_event(24'h000300, 16'h0020);
        for (int k = 0; k < 64; k++) exp_q.push_back(dat(2, 32'h0100_0000 + 32'(k)));
        exp_q.push_back(trl(16'd66));
        finish_event("t3a", 1000);
        start_event(24'h000301, 16'h0021);
        for (int k = 64; k < 100; k++) exp_q.push_back(dat(2, 32'h0100_0000 + 32'(k)));
        exp_q.push_back(trl(16'd38));
        finish_event("t3b", 1000);

        // TDC1 never answers
        stall = 4'b0010;
        load(0, 1, 32'h0000_0400);
        load(1, 1, 32'h0000_0401);
        load(2, 1, 32'h0000_0402);
        start_event(24'h000400, 16'h0030);
        exp_q.push_back(dat(0, 32'h0000_0400));
        exp_q.push_back(dat(2, 32'h0000_0402));
        exp_q.push_back(trl(16'd4));
        finish_event("t4", 300);
        chk("t4_timeout_error", 64'(timeout_error), 64'd1);
        stall = '0;

        // backpressure during EMIT
        load(3, 2, 32'h0000_0500);
        start_event(24'h000500, 16'h0040);
        @(negedge clk);
        chk("t5_timeout_cleared", 64'(timeout_error), 64'd0);
        @(posedge clk) #1 out_ready = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t5_dat_seen", 64'(out_valid), 64'd1);
        snap = data_out;
        chk("t5_dat_first", snap, dat(3, 32'h0000_0500));
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk($sformatf("t5_hold_data%0d", k), data_out, snap);
            chk($sformatf("t5_hold_valid%0d", k), 64'(out_valid), 64'd1);
            chk($sformatf("t5_hold_noread%0d", k), 64'(read_enable), 64'd0);
        end
        @(posedge clk) #1 out_ready = 1'b1;
        exp_q.push_back(dat(3, 32'h0000_0500));
        exp_q.push_back(dat(3, 32'h0000_0501));
        exp_q.push_back(trl(16'd4));
        finish_event("t5", 300);

        // reset while waiting for input_ready
        load(0, 1, 32'h0000_0600);
        start_event(24'h000600, 16'h0050);
        n = 0;
        while (read_enable == '0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t6_strobe_seen", 64'(read_enable), 64'd1);
        @(posedge clk) #1 rst = 1'b1;
        #1;
        chk("t6_rst_read_enable", 64'(read_enable), 64'd0);
        chk("t6_rst_out_valid", 64'(out_valid), 64'd0);
        chk("t6_rst_data_out", data_out, 64'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (10) @(posedge clk);
        chk("t6_no_trailer", 64'(done), 64'd0);
        for (int i = 0; i < N; i++) load(i, 1, 32'h0000_0700 + 32'(i));
        start_event(24'h000700, 16'h0060);
        for (int i = 0; i < N; i++) exp_q.push_back(dat(i, 32'h0000_0700 + 32'(i)));
        exp_q.push_back(trl(16'd6));
        finish_event("t6", 300);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tdc_readout_scheduler.md
Name: tdc_readout_scheduler

Overview:
- Sequences event readout from N_TDC HPTDC readout FIFOs into the 64-bit USB transmit word stream.
- On each transmit request, emits one header, then drains the TDC FIFOs in rotating round-robin order with a per-grant word cap, then emits a trailer.
- Sits between the per-TDC FIFOs and the transmit/serializer stage. It is the single owner of all FIFO read enables and of data_out.

Parameters:
- N_TDC, 4, number of TDC FIFOs (2..8).
- MAX_WORDS, 64, maximum words taken from one TDC per grant (1..255).
- FEC_ID, 12'h00A, front-end card ID placed in the header.
- TIMEOUT, 4, cycles to wait for input_ready after a read strobe.

Ports:
- clk, in, 1, system clock.
- rst, in, 1, asynchronous active-high reset.
- transmit_request, in, 1, level; starts an event when sampled high in IDLE.
- event_number, in, 24, latched at event start.
- bunch_number, in, 16, latched at event start; bits [11:0] are used.
- empty, in, N_TDC, per-FIFO empty flags.
- read_enable, out, N_TDC, one-hot read strobe, at most one bit high.
- data_in, in, 32*N_TDC, packed FIFO data; TDC i occupies [32i+31:32i].
- input_ready, in, N_TDC, high exactly one cycle after the read strobe, with data valid.
- data_out, out, 64, output word.
- out_valid, out, 1, data_out is valid.
- out_ready, in, 1, downstream accepts the word.
- transmit_complete, out, 1, one-cycle pulse after the trailer is accepted.
- timeout_error, out, 1, sticky; cleared at the next event start.

Behaviour:
- Reset (async, immediate): state IDLE, read_enable=0, data_out=0, out_valid=0, transmit_complete=0, timeout_error=0, rr_ptr=0, word_cnt=0. A reset mid-event abandons the event and emits no trailer.
- Output handshake: a word transfers when out_valid && out_ready. data_out and out_valid are held stable until the transfer.
- States and transitions:
  - IDLE: when transmit_request=1, latch event_number and bunch_number, clear the visited mask, clear timeout_error, set word_cnt=0, go to HEADER.
  - HEADER: present {4'hA, 4'h0, event_number[23:0], bunch_number[11:0], FEC_ID, 4'h0, 4'h0}. On transfer, word_cnt+1, go to SELECT.
  - SELECT: grant the first TDC scanning from rr_ptr upward (mod N_TDC) that is unvisited and has empty=0. Mark it visited, clear the per-grant count, go to READ. If no candidate exists, go to TRAILER. Takes one cycle.
  - READ: assert read_enable[g] for exactly one cycle, go to WAIT.
  - WAIT: on input_ready[g], capture the word and go to EMIT. After TIMEOUT cycles without input_ready, set timeout_error, drop the word, go to SELECT (the grant ends).
  - EMIT: present {4'h3, 1'b0, g[2:0], 24'h0, word[31:0]}. On transfer: word_cnt+1, grant count+1. Then:
    - if word[31:28]==4'h3 (TDC trailer), go to SELECT;
    - else if grant count==MAX_WORDS, go to SELECT;
    - else if empty[g]==1, go to SELECT;
    - otherwise go to READ.
  - TRAILER: present {4'h5, 4'h0, 8'h0, word_cnt+1 (16 bits, includes the trailer), 32'h0}. On transfer, pulse transmit_complete, set rr_ptr=(rr_ptr+1) mod N_TDC, go to IDLE.
- Each TDC is granted at most once per event. A FIFO that goes non-empty after its grant waits for the next event.
- Latency: the first header is presented the cycle after transmit_request is sampled. With out_ready held high, each FIFO word costs 4 cycles (READ, WAIT, EMIT, plus the transfer cycle).
- transmit_request is ignored outside IDLE. Dropping it mid-event does not abort the event.
- The read strobe is never asserted while empty[g]=1 is sampled in the same cycle. empty is rechecked before every READ.
- word_cnt is 16 bits and saturates at 16'hFFFF; it cannot wrap.
- Backpressure: the next READ is not issued until the EMIT transfer completes, so there is never more than one word in flight.

Decomposition:
- Package ctpps_readout_pkg holds:
  - word-type codes HDR=4'hA, DAT=4'h3, TRL=4'h5;
  - the TDC word type TDC_TRAILER=4'h3;
  - the state enum.
- Sub-module rr_select: combinational rotating-priority picker. Inputs are the candidate mask (~empty & ~visited) and rr_ptr. Outputs are grant index and grant valid.

Test Plan:
- FIFO0 has 3 words ending in 32'h3000_0003, others empty, event_number=24'h000123 -> header 64'hA000_0123_xxx0_0A00, three DAT words tagged TDC 0, trailer count 16'd5, transmit_complete pulse.
- All 4 FIFOs non-empty, two consecutive events -> grant order 0,1,2,3 in the first event and 1,2,3,0 in the second.
- FIFO2 holds 100 non-trailer words, MAX_WORDS=64 -> 64 DAT words this event, 36 in the next; trailer counts 66 and 38.
- input_ready never returns for TDC1 -> after 4 WAIT cycles timeout_error=1, TDC1 skipped, event still ends with a trailer.
- out_ready held low for 10 cycles during EMIT -> data_out stable, no read_enable pulses until the transfer.
- rst asserted during WAIT -> read_enable, out_valid and data_out go 0 immediately; the next event starts cleanly with rr_ptr=0.
